uart_txfsm: RTL and testbench

UART transmit framer; the transmit-side counterpart of the UART receive FSM in the UART block.
- Pops bytes from the TX FIFO and serialises each one onto the line as: start bit, 8 data bits (LSB first), optional parity bit, then 1 or 2 stop bits.
- Each bit lasts 2**OVS_LOG2 cycles of baud_clk_16x.
- Sits between the TX FIFO and the `so` pad, beside the receive FSM, and shares its config fields.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_sync2.sv | 27 ++
 rtl/uart_txfsm.sv | 160 ++++++++++++++++
 tb/tb_uart_txfsm.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, parity/stop constants and a parity helper.
// Used by both the transmit and the receive FSMs.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP1  = 3'd4,
    TX_STOP2  = 3'd5
  } tx_state_e;

  localparam logic [1:0] PRI_NONE = 2'b00;
  localparam logic [1:0] PRI_EVEN = 2'b10;
  localparam logic [1:0] PRI_ODD  = 2'b11;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  // acc is the XOR of all data bits; odd mode inverts it
  function automatic logic parity_bit(input logic acc, input logic [1:0] mode);
    return mode[0] ? ~acc : acc;
  endfunction

endpackage

// File: rtl/uart_tx_sync2.sv
// Two-flop synchroniser with a configurable reset value.
module uart_tx_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // double-flop capture of the asynchronous input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_txfsm.sv
// UART transmit framer: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Optional UART_TX_CTS_EN adds a cts_n flow-control input gating frame starts.
module uart_txfsm
  import uart_pkg::*;
#(
  parameter int OVS_LOG2 = 4
) (
  input  logic       baud_clk_16x,
  input  logic       reset_n,
  input  logic       cfg_tx_enable,
  input  logic       cfg_stop_bit,
  input  logic [1:0] cfg_pri_mod,
`ifdef UART_TX_CTS_EN
  input  logic       cts_n,
`endif
  input  logic       fifo_empty,
  output logic       fifo_rd,
  input  logic [7:0] fifo_rdata,
  output logic       so,
  output logic       tx_busy
);

  localparam logic [OVS_LOG2-1:0] PH_ONE  = {{(OVS_LOG2-1){1'b0}}, 1'b1};
  localparam logic [OVS_LOG2-1:0] PH_LAST = {OVS_LOG2{1'b1}};

  tx_state_e           state_r;
  logic [OVS_LOG2-1:0] ph_r;
  logic [2:0]          bitcnt_r;
  logic [7:0]          shreg_r;
  logic                par_r;
  logic [1:0]          mode_r;
  logic                stop_r;
  logic                so_r;
  logic                fifo_rd_r;
  logic                tx_busy_r;
  logic                bit_end_s;
  logic                cts_ok_s;

  assign bit_end_s = (ph_r == PH_LAST);

`ifdef UART_TX_CTS_EN
  logic cts_n_sync_s;

  uart_tx_sync2 #(.RESET_VAL(1'b1)) u_cts_sync (
    .clk     (baud_clk_16x),
    .reset_n (reset_n),
    .d       (cts_n),
    .q       (cts_n_sync_s)
  );

  assign cts_ok_s = ~cts_n_sync_s;
`else
  assign cts_ok_s = 1'b1;
`endif

  // frame sequencer; so lags the state by one cycle so it falls the edge after fifo_rd
  always_ff @(posedge baud_clk_16x or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= TX_IDLE;
      ph_r      <= '0;
      bitcnt_r  <= 3'd0;
      shreg_r   <= 8'h00;
      par_r     <= 1'b0;
      mode_r    <= PRI_NONE;
      stop_r    <= STOP_ONE;
      so_r      <= 1'b1;
      fifo_rd_r <= 1'b0;
      tx_busy_r <= 1'b0;
    end else if (!cfg_tx_enable) begin
      state_r   <= TX_IDLE;
      ph_r      <= '0;
      bitcnt_r  <= 3'd0;
      shreg_r   <= 8'h00;
      par_r     <= 1'b0;
      mode_r    <= PRI_NONE;
      stop_r    <= STOP_ONE;
      so_r      <= 1'b1;
      fifo_rd_r <= 1'b0;
      tx_busy_r <= 1'b0;
    end else begin
      fifo_rd_r <= 1'b0;
      ph_r      <= ph_r + PH_ONE;
      case (state_r)
        TX_IDLE: begin
          so_r      <= 1'b1;
          tx_busy_r <= 1'b0;
          ph_r      <= '0;
          if (!fifo_empty && cts_ok_s) begin
            fifo_rd_r <= 1'b1;
            shreg_r   <= fifo_rdata;
            mode_r    <= cfg_pri_mod;
            stop_r    <= cfg_stop_bit;
            par_r     <= 1'b0;
            bitcnt_r  <= 3'd0;
            tx_busy_r <= 1'b1;
            state_r   <= TX_START;
          end
        end
        TX_START: begin
          so_r <= 1'b0;
          if (bit_end_s) begin
            ph_r     <= '0;
            bitcnt_r <= 3'd0;
            state_r  <= TX_DATA;
          end
        end
        TX_DATA: begin
          so_r <= shreg_r[0];
          if (bit_end_s) begin
            ph_r     <= '0;
            shreg_r  <= {1'b0, shreg_r[7:1]};
            par_r    <= par_r ^ shreg_r[0];
            bitcnt_r <= bitcnt_r + 3'd1;
            if (bitcnt_r == 3'd7) begin
              state_r <= mode_r[1] ? TX_PARITY : TX_STOP1;
            end
          end
        end
        TX_PARITY: begin
          so_r <= parity_bit(par_r, mode_r);
          if (bit_end_s) begin
            ph_r    <= '0;
            state_r <= TX_STOP1;
          end
        end
        TX_STOP1: begin
          so_r <= 1'b1;
          if (bit_end_s) begin
            ph_r <= '0;
            if (stop_r == STOP_TWO) begin
              state_r <= TX_STOP2;
            end else begin
              state_r   <= TX_IDLE;
              tx_busy_r <= 1'b0;
            end
          end
        end
        TX_STOP2: begin
          so_r <= 1'b1;
          if (bit_end_s) begin
            ph_r      <= '0;
            state_r   <= TX_IDLE;
            tx_busy_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= TX_IDLE;
          ph_r      <= '0;
          so_r      <= 1'b1;
          tx_busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign so      = so_r;
  assign fifo_rd = fifo_rd_r;
  assign tx_busy = tx_busy_r;

endmodule

// File: tb/tb_uart_txfsm.sv
// Directed self-checking bench for uart_txfsm with a queue-based FWFT FIFO model.
module tb_uart_txfsm;

  logic       baud_clk_16x = 1'b0;
  logic       reset_n;
  logic       cfg_tx_enable;
  logic       cfg_stop_bit;
  logic [1:0] cfg_pri_mod;
  logic       fifo_empty;
  logic       fifo_rd;
  logic [7:0] fifo_rdata;
  logic       so;
  logic       tx_busy;
`ifdef UART_TX_CTS_EN
  logic       cts_n;
`endif

  int         n_checks = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         rd_count = 0;
  int         last_rd_cyc = 0;
  int         busy_cycles = 0;
  logic [7:0] fifo_q[$];

  uart_txfsm #(.OVS_LOG2(4)) dut (
    .baud_clk_16x  (baud_clk_16x),
    .reset_n       (reset_n),
    .cfg_tx_enable (cfg_tx_enable),
    .cfg_stop_bit  (cfg_stop_bit),
    .cfg_pri_mod   (cfg_pri_mod),
`ifdef UART_TX_CTS_EN
    .cts_n         (cts_n),
`endif
    .fifo_empty    (fifo_empty),
    .fifo_rd       (fifo_rd),
    .fifo_rdata    (fifo_rdata),
    .so            (so),
    .tx_busy       (tx_busy)
  );

  initial forever #5 baud_clk_16x = ~baud_clk_16x;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic refresh_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    refresh_fifo();
  endtask

  // One clock; all sampling and FIFO bookkeeping happen on the falling edge.
  task automatic tick();
    logic [7:0] dropped;
    @(posedge baud_clk_16x);
    @(negedge baud_clk_16x);
    cyc++;
    if (fifo_rd === 1'b1) begin
      n_checks++;
      if (fifo_q.size() == 0) begin
        n_err++;
        $display("FAIL underflow: fifo_rd=1 while FIFO empty at cycle %0d", cyc);
      end else begin
        dropped = fifo_q.pop_front();
      end
      rd_count++;
      last_rd_cyc = cyc;
    end
    if (tx_busy === 1'b1) busy_cycles++;
    refresh_fifo();
  endtask

  // bits[0] is the first bit on the line (start bit)
  task automatic check_frame(input logic [11:0] bits, input int nbits, input string name,
                             output int fall_cyc);
    int   w;
    logic bad;
    logic got;
    w = 0;
    while (so !== 1'b0 && w < 400) begin
      tick();
      w++;
    end
    fall_cyc = cyc;
    n_checks++;
    if (so !== 1'b0) begin
      n_err++;
      $display("FAIL %s start_timeout: so=%b, want 0 within 400 cycles", name, so);
    end else begin
      for (int b = 0; b < nbits; b++) begin
        bad = 1'b0;
        got = bits[b];
        for (int c = 0; c < 16; c++) begin
          if (!(b == 0 && c == 0)) tick();
          if (so !== bits[b]) begin
            bad = 1'b1;
            got = so;
          end
        end
        n_checks++;
        if (bad) begin
          n_err++;
          $display("FAIL %s bit%0d: so=%b, want %b for 16 cycles", name, b, got, bits[b]);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    cfg_tx_enable = 1'b0;
    cfg_stop_bit  = 1'b0;
    cfg_pri_mod   = 2'b00;
`ifdef UART_TX_CTS_EN
    cts_n         = 1'b0;
`endif
    refresh_fifo();
    repeat (3) tick();
    n_checks++;
    if (so !== 1'b1 || fifo_rd !== 1'b0 || tx_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: so=%b fifo_rd=%b tx_busy=%b, want 1 0 0", so, fifo_rd, tx_busy);
    end
    reset_n       = 1'b1;
    cfg_tx_enable = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (so !== 1'b1 || tx_busy !== 1'b0 || rd_count !== 0) begin
      n_err++;
      $display("FAIL idle_empty: so=%b tx_busy=%b rd_count=%0d, want 1 0 0", so, tx_busy, rd_count);
    end
  endtask

  task automatic test_8n1();
    int f;
    int rd0;
    rd0 = rd_count;
    busy_cycles = 0;
    push(8'hA5);
    check_frame({2'b00, 1'b1, 8'hA5, 1'b0}, 10, "8n1_a5", f);
    n_checks++;
    if (f - last_rd_cyc !== 1) begin
      n_err++;
      $display("FAIL 8n1_fall_delay: so fell %0d cycles after fifo_rd, want 1", f - last_rd_cyc);
    end
    repeat (5) tick();
    n_checks++;
    if (rd_count - rd0 !== 1) begin
      n_err++;
      $display("FAIL 8n1_rd_pulses: got %0d, want 1", rd_count - rd0);
    end
    n_checks++;
    if (busy_cycles !== 160) begin
      n_err++;
      $display("FAIL 8n1_busy_len: got %0d cycles, want 160", busy_cycles);
    end
    n_checks++;
    if (tx_busy !== 1'b0 || so !== 1'b1) begin
      n_err++;
      $display("FAIL 8n1_back_idle: tx_busy=%b so=%b, want 0 1", tx_busy, so);
    end
  endtask

  task automatic test_parity();
    logic [7:0] vbyte [0:2];
    logic [1:0] vmode [0:2];
    logic       vpar  [0:2];
    int         f;
    vbyte[0] = 8'hA5; vmode[0] = 2'b10; vpar[0] = 1'b0;
    vbyte[1] = 8'h01; vmode[1] = 2'b11; vpar[1] = 1'b0;
    vbyte[2] = 8'h01; vmode[2] = 2'b10; vpar[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cfg_pri_mod = vmode[i];
      busy_cycles = 0;
      push(vbyte[i]);
      check_frame({1'b0, 1'b1, vpar[i], vbyte[i], 1'b0}, 11, $sformatf("parity%0d", i), f);
      repeat (4) tick();
      n_checks++;
      if (busy_cycles !== 176) begin
        n_err++;
        $display("FAIL parity%0d_busy_len: got %0d cycles, want 176", i, busy_cycles);
      end
    end
    cfg_pri_mod = 2'b00;
  endtask

  task automatic test_back_to_back();
    int f1;
    int f2;
    cfg_stop_bit = 1'b1;
    push(8'h55);
    push(8'h3C);
    check_frame({1'b1, 1'b1, 8'h55, 1'b0}, 11, "b2b_first", f1);
    check_frame({1'b1, 1'b1, 8'h3C, 1'b0}, 11, "b2b_second", f2);
    n_checks++;
    if (f2 - f1 !== 177) begin
      n_err++;
      $display("FAIL b2b_period: got %0d cycles, want 177", f2 - f1);
    end
    n_checks++;
    if (f2 - last_rd_cyc !== 1) begin
      n_err++;
      $display("FAIL b2b_rd_in_idle: fifo_rd %0d cycles before start, want 1", f2 - last_rd_cyc);
    end
    repeat (20) tick();
    cfg_stop_bit = 1'b0;
  endtask

  task automatic test_disable();
    int   w;
    int   rd0;
    int   f;
    logic bad;
    push(8'hFF);
    push(8'h81);
    w = 0;
    while (so !== 1'b0 && w < 100) begin
      tick();
      w++;
    end
    repeat (69) tick();
    cfg_tx_enable = 1'b0;
    tick();
    n_checks++;
    if (so !== 1'b1 || tx_busy !== 1'b0) begin
      n_err++;
      $display("FAIL disable_abort: so=%b tx_busy=%b, want 1 0", so, tx_busy);
    end
    rd0 = rd_count;
    bad = 1'b0;
    repeat (40) begin
      tick();
      if (so !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (rd_count !== rd0 || bad) begin
      n_err++;
      $display("FAIL disable_hold: rd_pulses=%0d line_disturbed=%b, want 0 0", rd_count - rd0, bad);
    end
    cfg_tx_enable = 1'b1;
    check_frame({2'b00, 1'b1, 8'h81, 1'b0}, 10, "reenable_81", f);
    n_checks++;
    if (rd_count - rd0 !== 1) begin
      n_err++;
      $display("FAIL reenable_rd: got %0d pulses, want 1", rd_count - rd0);
    end
    repeat (5) tick();
  endtask

  task automatic test_cfg_change();
    int w;
    int rd0;
    int f;
    rd0 = rd_count;
    push(8'h3C);
    w = 0;
    while (rd_count == rd0 && w < 20) begin
      tick();
      w++;
    end
    cfg_pri_mod = 2'b11;
    push(8'h0F);
    check_frame({2'b00, 1'b1, 8'h3C, 1'b0}, 10, "cfg_mid_frame", f);
    check_frame({1'b0, 1'b1, 1'b1, 8'h0F, 1'b0}, 11, "cfg_next_odd", f);
    repeat (5) tick();
    cfg_pri_mod = 2'b00;
  endtask

  task automatic test_async_reset();
    int w;
    int rd0;
    rd0 = rd_count;
    push(8'h00);
    w = 0;
    while (rd_count == rd0 && w < 20) begin
      tick();
      w++;
    end
    repeat (3) tick();
    n_checks++;
    if (so !== 1'b0) begin
      n_err++;
      $display("FAIL areset_pre: so=%b, want 0 (start bit)", so);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (so !== 1'b1 || tx_busy !== 1'b0) begin
      n_err++;
      $display("FAIL areset_immediate: so=%b tx_busy=%b, want 1 0", so, tx_busy);
    end
    @(negedge baud_clk_16x);
    reset_n = 1'b1;
    repeat (20) tick();
    n_checks++;
    if (so !== 1'b1 || tx_busy !== 1'b0) begin
      n_err++;
      $display("FAIL areset_after: so=%b tx_busy=%b, want 1 0", so, tx_busy);
    end
  endtask

`ifdef UART_TX_CTS_EN
  task automatic test_cts();
    int   w;
    int   rd0;
    int   f;
    logic bad;
    cts_n = 1'b1;
    repeat (4) tick();
    rd0 = rd_count;
    push(8'h12);
    bad = 1'b0;
    repeat (30) begin
      tick();
      if (so !== 1'b1) bad = 1'b1;
    end
    n_checks++;
    if (rd_count !== rd0 || bad) begin
      n_err++;
      $display("FAIL cts_block: rd_pulses=%0d line_disturbed=%b, want 0 0", rd_count - rd0, bad);
    end
    cts_n = 1'b0;
    w = 0;
    while (rd_count == rd0 && w < 10) begin
      tick();
      w++;
    end
    n_checks++;
    if (rd_count == rd0 || w > 3) begin
      n_err++;
      $display("FAIL cts_start_latency: got %0d cycles, want <= 3", w);
    end
    cts_n = 1'b1;
    push(8'h34);
    check_frame({2'b00, 1'b1, 8'h12, 1'b0}, 10, "cts_complete", f);
    rd0 = rd_count;
    repeat (40) tick();
    n_checks++;
    if (rd_count !== rd0 || so !== 1'b1) begin
      n_err++;
      $display("FAIL cts_next_blocked: rd_pulses=%0d so=%b, want 0 1", rd_count - rd0, so);
    end
    cts_n = 1'b0;
    check_frame({2'b00, 1'b1, 8'h34, 1'b0}, 10, "cts_resume", f);
    repeat (5) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_disable();
    test_cfg_change();
    test_async_reset();
`ifdef UART_TX_CTS_EN
    test_cts();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
